// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ID/EX issue stage: RV32I opcodes, ALU operation
// codes, branch encoding and the decoded control bundle.
package alu_issue_stage_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_PASS = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_SLT  = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10
    } branch_e;

    typedef struct packed {
        alu_op_e alu_ctrl;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        branch_e branch;
        logic    illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_ctrl:  ALU_PASS,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        branch:    BR_NONE,
        illegal:   1'b0
    };

    // funct3 map shared by R-type and I-ALU; ALU_PASS marks an unsupported funct3
    function automatic alu_op_e f3_alu_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b100:  return ALU_XOR;
            3'b010:  return ALU_SLT;
            3'b001:  return ALU_SLL;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// Combinational RV32I decode from opcode/funct fields into the ALU control
// bundle and operand pair.
module alu_ctrl_decoder
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [REG_AW-1:0] rd,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] pc,
    output ctrl_t             ctrl,
    output logic [DATA_W-1:0] src0,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_AW-1:0] rd_issue
);

    logic    legal;
    alu_op_e f3_op;

    always_comb begin
        ctrl       = CTRL_NOP;
        src0       = rs1_data;
        src1       = rs2_data;
        store_data = rs2_data;
        rd_issue   = rd;
        legal      = 1'b0;
        f3_op      = f3_alu_op(funct3);

        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                if (funct3 == 3'b000 && funct7 == F7_ALT) begin
                    ctrl.alu_ctrl = ALU_SUB;
                    legal         = 1'b1;
                end else if (funct7 == F7_BASE && f3_op != ALU_PASS) begin
                    ctrl.alu_ctrl = f3_op;
                    legal         = 1'b1;
                end
            end
            OP_IALU: begin
                // funct7 is immediate bits here, except for SLLI
                src1           = imm;
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = f3_op;
                legal          = (f3_op != ALU_PASS) &&
                                 (funct3 != 3'b001 || funct7 == F7_BASE);
            end
            OP_LOAD: begin
                src1           = imm;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                legal          = (funct3 == 3'b010);
            end
            OP_STORE: begin
                src1           = imm;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.mem_write = 1'b1;
                legal          = (funct3 == 3'b010);
            end
            OP_BRANCH: begin
                ctrl.alu_ctrl = ALU_SUB;
                if (funct3 == 3'b000) begin
                    ctrl.branch = BR_BEQ;
                    legal       = 1'b1;
                end else if (funct3 == 3'b001) begin
                    ctrl.branch = BR_BNE;
                    legal       = 1'b1;
                end
            end
            OP_LUI: begin
                src1           = imm;
                ctrl.alu_ctrl  = ALU_PASS;
                ctrl.reg_write = 1'b1;
                legal          = 1'b1;
            end
            OP_JAL: begin
                src0           = pc;
                src1           = DATA_W'(4);
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.reg_write = 1'b1;
                legal          = 1'b1;
            end
            default: ;
        endcase

        if (!legal) begin
            ctrl         = CTRL_NOP;
            ctrl.illegal = 1'b1;
            rd_issue     = '0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the instruction and holds it in a main register
// backed by a one-entry skid register so ready_o comes straight from a flop.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [3:0]        alu_ctrl_o,
    output logic [DATA_W-1:0] src0_o,
    output logic [DATA_W-1:0] src1_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [1:0]        branch_o,
    output logic              illegal_o
);

    typedef struct packed {
        ctrl_t             ctrl;
        logic [DATA_W-1:0] src0;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] rd;
    } bundle_t;

    bundle_t dec_q;
    bundle_t m_q;
    bundle_t s_q;
    logic    m_valid;
    logic    s_valid;
    logic    in_xfer;
    logic    out_xfer;

    alu_ctrl_decoder #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_decoder (
        .opcode     (opcode_i),
        .funct3     (funct3_i),
        .funct7     (funct7_i),
        .rd         (rd_i),
        .rs1_data   (rs1_data_i),
        .rs2_data   (rs2_data_i),
        .imm        (imm_i),
        .pc         (pc_i),
        .ctrl       (dec_q.ctrl),
        .src0       (dec_q.src0),
        .src1       (dec_q.src1),
        .store_data (dec_q.store_data),
        .rd_issue   (dec_q.rd)
    );

    assign ready_o  = ~s_valid;
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = m_valid & ready_i;

    // S can only be occupied while M is; it refills M on the next drain
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else if (flush_i) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (out_xfer && s_valid) begin
            m_q     <= s_q;
            s_valid <= 1'b0;
        end else if (in_xfer && (!m_valid || out_xfer)) begin
            m_q     <= dec_q;
            m_valid <= 1'b1;
        end else if (in_xfer) begin
            s_q     <= dec_q;
            s_valid <= 1'b1;
        end else if (out_xfer) begin
            m_valid <= 1'b0;
        end
    end

    assign valid_o      = m_valid;
    assign alu_ctrl_o   = m_q.ctrl.alu_ctrl;
    assign src0_o       = m_q.src0;
    assign src1_o       = m_q.src1;
    assign store_data_o = m_q.store_data;
    assign rd_o         = m_q.rd;
    // Enables are qualified so a drained bundle's stale fields cannot act
    assign reg_write_o  = m_valid & m_q.ctrl.reg_write;
    assign mem_read_o   = m_valid & m_q.ctrl.mem_read;
    assign mem_write_o  = m_valid & m_q.ctrl.mem_write;
    assign branch_o     = m_valid ? m_q.ctrl.branch : BR_NONE;
    assign illegal_o    = m_valid & m_q.ctrl.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, table-driven bench for alu_issue_stage plus stall, flush and
// asynchronous reset sequences.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [4:0]  rd_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] src0_o;
    logic [31:0] src1_o;
    logic [31:0] store_data_o;
    logic [4:0]  rd_o;
    logic        reg_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [1:0]  branch_o;
    logic        illegal_o;

    int tests;
    int fails;

    alu_issue_stage #(
        .DATA_W (32),
        .REG_AW (5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .opcode_i     (opcode_i),
        .funct3_i     (funct3_i),
        .funct7_i     (funct7_i),
        .rd_i         (rd_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .imm_i        (imm_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .alu_ctrl_o   (alu_ctrl_o),
        .src0_o       (src0_o),
        .src1_o       (src1_o),
        .store_data_o (store_data_o),
        .rd_o         (rd_o),
        .reg_write_o  (reg_write_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .branch_o     (branch_o),
        .illegal_o    (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  e_alu;
        logic [31:0] e_s0;
        logic        chk_s0;
        logic [31:0] e_s1;
        logic        chk_s1;
        logic [31:0] e_sd;
        logic        chk_sd;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_mr;
        logic        e_mw;
        logic [1:0]  e_br;
        logic        e_ill;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        opcode_i   = v.op;
        funct3_i   = v.f3;
        funct7_i   = v.f7;
        rd_i       = v.rd;
        rs1_data_i = v.rs1;
        rs2_data_i = v.rs2;
        imm_i      = v.imm;
        pc_i       = v.pc;
    endtask

    task automatic put_add(input logic [4:0] rd);
        opcode_i   = 7'b0110011;
        funct3_i   = 3'b000;
        funct7_i   = 7'b0000000;
        rd_i       = rd;
        rs1_data_i = 32'd1;
        rs2_data_i = 32'd2;
        imm_i      = 32'd0;
        pc_i       = 32'd0;
        valid_i    = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},    {31'd0, valid_o},     32'd0);
        chk({tag, "_ready"},    {31'd0, ready_o},     32'd1);
        chk({tag, "_alu"},      {28'd0, alu_ctrl_o},  32'd0);
        chk({tag, "_rw"},       {31'd0, reg_write_o}, 32'd0);
        chk({tag, "_mr_mw"},    {30'd0, mem_read_o, mem_write_o}, 32'd0);
        chk({tag, "_branch"},   {30'd0, branch_o},    32'd0);
        chk({tag, "_illegal"},  {31'd0, illegal_o},   32'd0);
        chk({tag, "_src0"},     src0_o,               32'd0);
        chk({tag, "_rd"},       {27'd0, rd_o},        32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //          name     op          f3      f7     rd     rs1           rs2           imm           pc          alu     s0            c  s1            c  sd           c  rd     rw mr mw br     ill
        vecs[0]  = '{"add",   7'b0110011, 3'd0, 7'h00, 5'd3,  32'd5,        32'd7,        32'd0,        32'd0,      4'b0010, 32'd5,        1, 32'd7,        1, 32'd0,       0, 5'd3,  1, 0, 0, 2'b00, 0};
        vecs[1]  = '{"sub",   7'b0110011, 3'd0, 7'h20, 5'd4,  32'd10,       32'd3,        32'd0,        32'd0,      4'b0011, 32'd10,       1, 32'd3,        1, 32'd0,       0, 5'd4,  1, 0, 0, 2'b00, 0};
        vecs[2]  = '{"beq",   7'b1100011, 3'd0, 7'h00, 5'd0,  32'd9,        32'd9,        32'd0,        32'd0,      4'b0011, 32'd9,        1, 32'd9,        1, 32'd0,       0, 5'd0,  0, 0, 0, 2'b01, 0};
        vecs[3]  = '{"lw",    7'b0000011, 3'd2, 7'h00, 5'd5,  32'd100,      32'd0,        32'd16,       32'd0,      4'b0010, 32'd100,      1, 32'd16,       1, 32'd0,       0, 5'd5,  1, 1, 0, 2'b00, 0};
        vecs[4]  = '{"sw",    7'b0100011, 3'd2, 7'h00, 5'd0,  32'd200,      32'hdead,     32'd8,        32'd0,      4'b0010, 32'd200,      1, 32'd8,        1, 32'hdead,    1, 5'd0,  0, 0, 1, 2'b00, 0};
        vecs[5]  = '{"bne",   7'b1100011, 3'd1, 7'h00, 5'd0,  32'd1,        32'd2,        32'd0,        32'd0,      4'b0011, 32'd1,        1, 32'd2,        1, 32'd0,       0, 5'd0,  0, 0, 0, 2'b10, 0};
        vecs[6]  = '{"andi",  7'b0010011, 3'd7, 7'h00, 5'd6,  32'h1234,     32'd0,        32'hff,       32'd0,      4'b0111, 32'h1234,     1, 32'hff,       1, 32'd0,       0, 5'd6,  1, 0, 0, 2'b00, 0};
        vecs[7]  = '{"or",    7'b0110011, 3'd6, 7'h00, 5'd7,  32'hf0,       32'h0f,       32'd0,        32'd0,      4'b0001, 32'hf0,       1, 32'h0f,       1, 32'd0,       0, 5'd7,  1, 0, 0, 2'b00, 0};
        vecs[8]  = '{"xori",  7'b0010011, 3'd4, 7'h00, 5'd8,  32'haa,       32'd0,        32'hff,       32'd0,      4'b0101, 32'haa,       1, 32'hff,       1, 32'd0,       0, 5'd8,  1, 0, 0, 2'b00, 0};
        vecs[9]  = '{"slt",   7'b0110011, 3'd2, 7'h00, 5'd9,  32'hffffffff, 32'd1,        32'd0,        32'd0,      4'b0100, 32'hffffffff, 1, 32'd1,        1, 32'd0,       0, 5'd9,  1, 0, 0, 2'b00, 0};
        vecs[10] = '{"slli",  7'b0010011, 3'd1, 7'h00, 5'd10, 32'd1,        32'd0,        32'd3,        32'd0,      4'b0110, 32'd1,        1, 32'd3,        1, 32'd0,       0, 5'd10, 1, 0, 0, 2'b00, 0};
        vecs[11] = '{"lui",   7'b0110111, 3'd0, 7'h00, 5'd11, 32'd0,        32'd0,        32'h12345000, 32'd0,      4'b0000, 32'd0,        0, 32'h12345000, 1, 32'd0,       0, 5'd11, 1, 0, 0, 2'b00, 0};
        vecs[12] = '{"jal",   7'b1101111, 3'd0, 7'h00, 5'd1,  32'h55,       32'd0,        32'd0,        32'h100,    4'b0010, 32'h100,      1, 32'd4,        1, 32'd0,       0, 5'd1,  1, 0, 0, 2'b00, 0};
        vecs[13] = '{"ecall", 7'b1110011, 3'd0, 7'h00, 5'd7,  32'd3,        32'd4,        32'd0,        32'd0,      4'b0000, 32'd0,        0, 32'd0,        0, 32'd0,       0, 5'd0,  0, 0, 0, 2'b00, 1};
        vecs[14] = '{"slli7", 7'b0010011, 3'd1, 7'h20, 5'd12, 32'd1,        32'd0,        32'd3,        32'd0,      4'b0000, 32'd0,        0, 32'd0,        0, 32'd0,       0, 5'd0,  0, 0, 0, 2'b00, 1};
        vecs[15] = '{"badf7", 7'b0110011, 3'd0, 7'h01, 5'd13, 32'd1,        32'd2,        32'd0,        32'd0,      4'b0000, 32'd0,        0, 32'd0,        0, 32'd0,       0, 5'd0,  0, 0, 0, 2'b00, 1};
        vecs[16] = '{"addin", 7'b0010011, 3'd0, 7'h7f, 5'd14, 32'd50,       32'd0,        32'hfffffffd, 32'd0,      4'b0010, 32'd50,       1, 32'hfffffffd, 1, 32'd0,       0, 5'd14, 1, 0, 0, 2'b00, 0};

        rst_i      = 1'b0;
        valid_i    = 1'b0;
        flush_i    = 1'b0;
        ready_i    = 1'b1;
        opcode_i   = '0;
        funct3_i   = '0;
        funct7_i   = '0;
        rd_i       = '0;
        rs1_data_i = '0;
        rs2_data_i = '0;
        imm_i      = '0;
        pc_i       = '0;

        #12;
        chk_reset_outputs("rst0");
        rst_i = 1'b1;
        step();

        // Back-to-back issue, one instruction per cycle with ready_i=1
        valid_i = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            step();
            chk({vecs[i].name, "_valid"}, {31'd0, valid_o}, 32'd1);
            chk({vecs[i].name, "_ready"}, {31'd0, ready_o}, 32'd1);
            chk({vecs[i].name, "_alu"}, {28'd0, alu_ctrl_o}, {28'd0, vecs[i].e_alu});
            if (vecs[i].chk_s0) chk({vecs[i].name, "_src0"}, src0_o, vecs[i].e_s0);
            if (vecs[i].chk_s1) chk({vecs[i].name, "_src1"}, src1_o, vecs[i].e_s1);
            if (vecs[i].chk_sd) chk({vecs[i].name, "_sdata"}, store_data_o, vecs[i].e_sd);
            chk({vecs[i].name, "_rd"}, {27'd0, rd_o}, {27'd0, vecs[i].e_rd});
            chk({vecs[i].name, "_rw"}, {31'd0, reg_write_o}, {31'd0, vecs[i].e_rw});
            chk({vecs[i].name, "_mr"}, {31'd0, mem_read_o}, {31'd0, vecs[i].e_mr});
            chk({vecs[i].name, "_mw"}, {31'd0, mem_write_o}, {31'd0, vecs[i].e_mw});
            chk({vecs[i].name, "_br"}, {30'd0, branch_o}, {30'd0, vecs[i].e_br});
            chk({vecs[i].name, "_ill"}, {31'd0, illegal_o}, {31'd0, vecs[i].e_ill});
        end
        valid_i = 1'b0;
        step();
        chk("drain_valid", {31'd0, valid_o}, 32'd0);
        chk("drain_rw", {31'd0, reg_write_o}, 32'd0);

        // Stall: fill M and S, then release and expect in-order issue
        ready_i = 1'b0;
        put_add(5'd21);
        step();
        chk("stall_a_valid", {31'd0, valid_o}, 32'd1);
        chk("stall_a_rd", {27'd0, rd_o}, 32'd21);
        chk("stall_a_ready", {31'd0, ready_o}, 32'd1);
        put_add(5'd22);
        step();
        chk("stall_b_ready", {31'd0, ready_o}, 32'd0);
        chk("stall_b_rd", {27'd0, rd_o}, 32'd21);
        put_add(5'd23);
        step();
        chk("stall_c_ready", {31'd0, ready_o}, 32'd0);
        chk("stall_c_valid", {31'd0, valid_o}, 32'd1);
        chk("stall_c_rd", {27'd0, rd_o}, 32'd21);
        ready_i = 1'b1;
        step();
        chk("rel1_rd", {27'd0, rd_o}, 32'd22);
        chk("rel1_valid", {31'd0, valid_o}, 32'd1);
        chk("rel1_ready", {31'd0, ready_o}, 32'd1);
        step();
        chk("rel2_rd", {27'd0, rd_o}, 32'd23);
        chk("rel2_valid", {31'd0, valid_o}, 32'd1);
        valid_i = 1'b0;
        step();
        chk("rel3_valid", {31'd0, valid_o}, 32'd0);

        // Flush with M and S full and a third instruction offered
        ready_i = 1'b0;
        put_add(5'd31);
        step();
        put_add(5'd32);
        step();
        chk("pre_flush_ready", {31'd0, ready_o}, 32'd0);
        put_add(5'd33);
        flush_i = 1'b1;
        step();
        chk("flush_valid", {31'd0, valid_o}, 32'd0);
        chk("flush_ready", {31'd0, ready_o}, 32'd1);
        chk("flush_rw", {31'd0, reg_write_o}, 32'd0);
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_flush_valid", {31'd0, valid_o}, 32'd0);
        end

        // Flush on an empty stage discards the instruction presented that cycle
        put_add(5'd34);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_in_valid", {31'd0, valid_o}, 32'd0);
        step();
        chk("flush_in_valid2", {31'd0, valid_o}, 32'd0);

        // Asynchronous reset in the middle of a stall
        ready_i = 1'b0;
        vecs[0].rd = 5'd9;
        drive(vecs[2]);
        valid_i = 1'b1;
        step();
        put_add(5'd12);
        step();
        chk("pre_rst_ready", {31'd0, ready_o}, 32'd0);
        chk("pre_rst_br", {30'd0, branch_o}, 32'd1);
        valid_i = 1'b0;
        #2;
        rst_i = 1'b0;
        #1;
        chk_reset_outputs("arst");
        #2;
        rst_i = 1'b1;
        ready_i = 1'b1;
        step();
        chk("after_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("after_rst_ready", {31'd0, ready_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage: the producer end of the ALU control interface.
- Decodes RV32I opcode/funct3/funct7 into the 4-bit alu_ctrl code and operand pair the ALU consumes.
- Registers the decoded bundle into the ID/EX pipeline register, with a valid/ready handshake on both sides and a one-entry skid buffer so ready_o is a pure register output.
- Sits between the register-file read and the ALU in the pipelined CPU.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_AW, 5, register address width

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- valid_i  input  1  ID presents an instruction
- ready_o  output  1  stage can accept (registered)
- opcode_i  input  7  inst[6:0]
- funct3_i  input  3  inst[14:12]
- funct7_i  input  7  inst[31:25]
- rd_i  input  REG_AW  destination register
- rs1_data_i  input  DATA_W  register-file read port 1
- rs2_data_i  input  DATA_W  register-file read port 2
- imm_i  input  DATA_W  sign-extended immediate from ID
- pc_i  input  DATA_W  instruction PC
- flush_i  input  1  squash all held and incoming instructions (branch taken)
- valid_o  output  1  EX bundle valid
- ready_i  input  1  EX accepts the bundle
- alu_ctrl_o  output  4  ALU operation code
- src0_o  output  DATA_W  ALU operand 0
- src1_o  output  DATA_W  ALU operand 1
- store_data_o  output  DATA_W  rs2 data for stores
- rd_o  output  REG_AW  destination register
- reg_write_o  output  1  write-back enable
- mem_read_o  output  1  load
- mem_write_o  output  1  store
- branch_o  output  2  00 none, 01 BEQ, 10 BNE
- illegal_o  output  1  unsupported encoding (bundle still issued; all enables forced 0)

Behaviour:
- ALU codes:
  - 0111 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLT (signed), 0101 XOR, 0110 SLL.
  - 0000 = pass src1 (emitted for LUI and for illegal encodings).
- Decode, combinational on the inputs:
  - R-type 0110011: f3 000 with f7 0000000 → ADD, with f7 0100000 → SUB; 111 AND; 110 OR; 100 XOR; 010 SLT; 001 (f7 0) SLL. src0=rs1, src1=rs2, reg_write=1.
  - I-ALU 0010011: same f3 map, ADD for 000 (ignore f7 except SLLI needs f7=0). src1=imm, reg_write=1.
  - LOAD 0000011 (f3 010): ADD, src1=imm, mem_read=1, reg_write=1.
  - STORE 0100011 (f3 010): ADD, src1=imm, mem_write=1, store_data=rs2.
  - BRANCH 1100011: f3 000 → branch=01, f3 001 → branch=10. SUB, src0=rs1, src1=rs2, reg_write=0.
  - LUI 0110111: pass code 0000, src1=imm, reg_write=1.
  - JAL 1101111: ADD, src0=pc, src1=4, reg_write=1 (link value).
  - Anything else: illegal=1, code 0000, reg_write/mem_read/mem_write/branch all 0, rd forced 0.
- Handshake:
  - Input transfer on valid_i&ready_o.
  - Output transfer on valid_o&ready_i.
  - valid_o never drops and the bundle never changes while valid_o=1 and ready_i=0.
- Storage: main register M (drives outputs) plus skid register S.
  - ready_o = ~S.valid.
  - Input transfer when M empty, or M draining this cycle → load M.
  - Input transfer when M held → load S.
  - On an output transfer with S valid → M←S and S empties, same edge.
- Latency: 1 cycle from input transfer to valid_o when the stage is empty.
- Throughput: 1/cycle with ready_i=1.
- flush_i=1 at an edge: M.valid and S.valid cleared; any instruction presented that cycle is discarded; ready_o=1 next cycle. Flush has priority over every simultaneous transfer.
- Reset: asynchronous on rst_i=0.
  - valid_o=0, ready_o=1 (S empty).
  - All data/control outputs 0 (alu_ctrl_o=0000, branch_o=00, illegal_o=0).
  - Mid-operation reset drops held instructions.
- Output data registers may hold stale values while valid_o=0, but control enables (reg_write_o, mem_*, branch_o) are 0 whenever valid_o=0.

Decomposition:
- Shared package: opcode constants, ALU code constants (ALU_AND=4'b0111, etc.), branch encoding, bundle struct typedef.
- One natural sub-module: alu_ctrl_decoder (pure combinational opcode/funct → bundle). The issue stage instantiates it and adds the M/S registers.

Test Plan:
- add x3,x1,x2 with rs1=5, rs2=7, ready_i=1 → next cycle valid_o=1, alu_ctrl 0010, src0=5, src1=7, reg_write=1, rd=3.
- sub (f7 0100000), then beq, then lw imm=16 back-to-back → codes 0011, 0011+branch 01, 0010+mem_read with src1=16; one per cycle.
- ready_i=0 for 3 cycles while 3 instructions are offered → M and S fill, ready_o=0 after the 2nd; on release they are issued in order with no loss or duplication.
- flush_i asserted with M and S full and valid_i=1 → next cycle valid_o=0, ready_o=1; none of the three appear later.
- opcode 1110011 → illegal_o=1, alu_ctrl 0000, all enables 0, rd_o=0.
- rst_i pulsed low asynchronously mid-stall → outputs immediately valid_o=0, ready_o=1, control outputs 0.
